seq_wide_adder_ctrl: RTL and testbench

Multi-cycle wide-operand adder controller. It accepts two `WIDTH*NSLICE`-bit operands over a valid/ready handshake and adds them one `WIDTH`-bit slice per cycle on a single shared `param_full_adder` instance, rippling the carry between slices through a register. It returns the full sum and carry-out over a second valid/ready handshake. It sits between an operand source and a result sink wherever a narrow adder datapath must serve wide additions.

---
 rtl/seq_adder_pkg.sv | 10 +
 rtl/param_full_adder.sv | 18 +
 rtl/seq_wide_adder_ctrl.sv | 113 +++++++++++
 tb/tb_seq_wide_adder_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_adder_pkg.sv
// Shared type definitions for the sequential wide-operand adder.
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_add_state_t;

endpackage

// File: rtl/param_full_adder.sv
// Combinational WIDTH-bit adder with carry in and carry out; one slice of the wide add.
module param_full_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign sum   = total[WIDTH-1:0];
  assign cout  = total[WIDTH];

endmodule

// File: rtl/seq_wide_adder_ctrl.sv
// Wide adder that ripples one WIDTH-bit slice per cycle through a single shared
// adder, with valid/ready handshakes on the operand and result sides.
module seq_wide_adder_ctrl
  import seq_adder_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int NSLICE = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH*NSLICE-1:0]  a,
  input  logic [WIDTH*NSLICE-1:0]  b,
  input  logic                     cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH*NSLICE-1:0]  sum,
  output logic                     cout,
  output logic                     busy
);

  localparam int TW = WIDTH * NSLICE;
  localparam int IW = $clog2(NSLICE);
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  seq_add_state_t   state;
  logic [IW-1:0]    idx;
  logic [TW-1:0]    a_r;
  logic [TW-1:0]    b_r;
  logic [TW-1:0]    sum_r;
  logic             carry_r;

  logic [WIDTH-1:0] slice_a;
  logic [WIDTH-1:0] slice_b;
  logic [WIDTH-1:0] slice_s;
  logic             slice_c;

  assign slice_a = a_r[idx*WIDTH +: WIDTH];
  assign slice_b = b_r[idx*WIDTH +: WIDTH];

  param_full_adder #(
    .WIDTH(WIDTH)
  ) u_fa (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_r),
    .sum  (slice_s),
    .cout (slice_c)
  );

  // Operand capture: data only, no reset needed since RUN is never entered without a load.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_r <= a;
      b_r <= b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry_r   <= 1'b0;
      sum_r     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            carry_r  <= cin;
            sum_r    <= '0;
            idx      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          sum_r[idx*WIDTH +: WIDTH] <= slice_s;
          carry_r                   <= slice_c;
          // idx parks on the last slice so it never wraps past NSLICE-1.
          if (idx == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign sum  = sum_r;
  assign cout = carry_r;

endmodule

// File: tb/tb_seq_wide_adder_ctrl.sv
// Bench for seq_wide_adder_ctrl: directed vectors plus a transaction-level model
// compared against the DUT every cycle.
module tb_seq_wide_adder_ctrl;

  localparam int W  = 4;
  localparam int NS = 4;
  localparam int TW = W * NS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] a;
  logic [TW-1:0] b;
  logic          cin;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] sum;
  logic          cout;
  logic          busy;

  seq_wide_adder_ctrl #(
    .WIDTH (W),
    .NSLICE(NS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an operation is in flight from accept until the
  // result handshake; its result is plain (a+b+cin) and appears NS cycles after accept.
  bit            started = 0;
  bit            inflight = 0;
  int            cyc = 0;
  logic [TW:0]   exp_res = '0;
  logic [TW:0]   last_res = '0;
  int            n_acc = 0;
  int            n_done = 0;
  longint        cycle = 0;
  longint        acc_cyc = 0;
  bit            have_prev = 0;
  logic          ov_prev = 1'b0;

  always @(posedge clk) begin
    cycle++;
    if (!rst_n) begin
      inflight  = 0;
      cyc       = 0;
      last_res  = '0;
      have_prev = 0;
    end else if (inflight) begin
      if (cyc == NS) begin
        if (out_ready) begin
          inflight = 0;
          last_res = exp_res;
          n_done++;
        end
      end else begin
        cyc++;
      end
    end else if (in_valid) begin
      if (have_prev)
        check("throughput_gap_ok", 64'(cycle - acc_cyc >= NS + 2), 64'd1);
      inflight  = 1;
      cyc       = 0;
      exp_res   = {1'b0, a} + {1'b0, b} + {{TW{1'b0}}, cin};
      n_acc++;
      have_prev = 1;
      acc_cyc   = cycle;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("in_ready", 64'(in_ready), 64'(!inflight));
      check("busy", 64'(busy), 64'(inflight));
      check("out_valid", 64'(out_valid), 64'(inflight && cyc == NS));
      if (inflight && cyc == NS)
        check("result", 64'({cout, sum}), 64'(exp_res));
      else if (!inflight)
        check("held_result", 64'({cout, sum}), 64'(last_res));
      if (out_valid === 1'b1 && ov_prev !== 1'b1)
        check("latency", 64'(cycle - acc_cyc), 64'(NS));
      ov_prev = out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return 1ns after the edge that accepted it.
  task automatic send(input logic [TW-1:0] ta, input logic [TW-1:0] tb_, input logic tc,
                      input bit keep);
    bit ok;
    ok       = 0;
    a        = ta;
    b        = tb_;
    cin      = tc;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    check("accept_within_bound", 64'(ok), 64'd1);
    tick();
    if (!keep) in_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int target, seen, guard, a0, d0;
    bit drained;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;

    // 1: reset
    tick();
    started = 1;
    tick();
    rst_n = 1'b1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sum", 64'(sum), 64'h0000);
    check("rst_cout", 64'(cout), 64'd0);

    // 2: full carry ripple
    out_ready = 1'b1;
    send(16'hFFFF, 16'h0001, 1'b0, 0);
    repeat (NS) tick();
    check("ripple_valid", 64'(out_valid), 64'd1);
    check("ripple_sum", 64'(sum), 64'h0000);
    check("ripple_cout", 64'(cout), 64'd1);
    check("ripple_model", 64'(exp_res), 64'h10000);
    tick();

    // 3: carry-in only
    send(16'h0000, 16'h0000, 1'b1, 0);
    repeat (NS) tick();
    check("cin_valid", 64'(out_valid), 64'd1);
    check("cin_sum", 64'(sum), 64'h0001);
    check("cin_cout", 64'(cout), 64'd0);
    tick();

    // 4: busy with a held second request, then result backpressure
    out_ready = 1'b0;
    send(16'h1234, 16'h4321, 1'b0, 1);
    a = 16'h0F0F;
    b = 16'h0101;
    check("busy_in_ready", 64'(in_ready), 64'd0);
    repeat (NS) tick();
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_sum", 64'(sum), 64'h5555);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_sum", 64'(sum), 64'h5555);
      check("stall_cout", 64'(cout), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    check("post_hs_in_ready", 64'(in_ready), 64'd1);
    check("post_hs_out_valid", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    check("held_req_busy", 64'(busy), 64'd1);
    repeat (NS) tick();
    check("held_req_valid", 64'(out_valid), 64'd1);
    check("held_req_sum", 64'(sum), 64'h1010);
    tick();

    // 5: reset in the middle of RUN
    send(16'hABCD, 16'h1111, 1'b0, 0);
    tick();
    rst_n = 1'b0;
    tick();
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_sum", 64'(sum), 64'h0000);
    check("midrst_cout", 64'(cout), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midrst_no_output", 64'(out_valid), 64'd0);
    end

    // 6: random operands with random result stalls
    a0       = n_acc;
    d0       = n_done;
    target   = n_acc + 200;
    seen     = n_acc;
    guard    = 0;
    a        = 16'($urandom);
    b        = 16'($urandom);
    cin      = 1'($urandom);
    in_valid = 1'b1;
    while (n_acc < target && guard < 20000) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
      guard++;
      if (n_acc != seen) begin
        seen = n_acc;
        a    = 16'($urandom);
        b    = 16'($urandom);
        cin  = 1'($urandom);
      end
    end
    check("random_within_bound", 64'(guard < 20000), 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drained   = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy === 1'b0) begin
        drained = 1;
        break;
      end
    end
    check("random_drained", 64'(drained), 64'd1);
    check("random_all_returned", 64'(n_done - d0), 64'(n_acc - a0));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
